// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the multi-port register file (regfile_mp) and its
//   clear sequencer (regfile_mp_clr):
//     - default parameter values (DW, DEPTH, NR, NW)
//     - clear-sequencer state type and encodings (ST_CLEAR, ST_RUN)
//     - win_port(): picks the write port that owns an address when several
//       ports target it in the same cycle (highest index wins)
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NR    = 2;
  localparam int DEF_NW    = 1;

  // Widest write-port count the file supports; hit vectors are sized to it.
  localparam int MAX_NW    = 2;

  typedef logic [0:0] state_t;
  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_RUN   = 1'b1;

  // Highest set bit of hit. Returns 0 when hit is empty, so callers must
  // qualify the result with |hit.
  function automatic int win_port(input logic [MAX_NW-1:0] hit);
    int idx;
    idx = 0;
    for (int p = 0; p < MAX_NW; p++) begin
      if (hit[p]) idx = p;
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_mp_clr.sv
// ---------------------------------------------------------------------------
// regfile_mp_clr
//   Clear sequencer for regfile_mp. After reset, and after a clr_req pulse
//   seen in ST_RUN, it walks every entry once (one per cycle, DEPTH cycles)
//   and requests a zero write to it, then returns to ST_RUN.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   clr_req   in   request a full clear (only honoured in ST_RUN)
//   state     out  current sequencer state (ST_CLEAR / ST_RUN)
//   busy      out  high while clearing
//   clr_we    out  zero-write enable for entry clr_addr
//   clr_addr  out  entry being cleared this cycle
// ---------------------------------------------------------------------------
module regfile_mp_clr
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output state_t        state,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  // One spare bit so the counter cannot wrap before the terminal compare.
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        // clr_req is ignored here: a clear in progress is never restarted.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = ST_RUN;
      end
      default: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state    = state_q;
  assign busy     = (state_q == ST_CLEAR);
  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = cnt_q[AW-1:0];

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port register file for the ID stage: NR registered
//   read ports (one-cycle latency) and NW write ports from WB. When several
//   write ports hit the same address in one cycle, the highest-index port
//   wins. A clear sequencer zeroes the array after reset and on clr_req.
//
//   Build option: define REGFILE_MP_BYPASS_EN to forward same-cycle write
//   data into the read registers (write-first). Without it reads capture the
//   array before the write (read-first).
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   raddr    in   NR*AW read addresses, port i at [i*AW +: AW]
//   rdata    out  NR*DW registered read data, port i at [i*DW +: DW]
//   rvalid   out  NR read-data valid bits
//   re       in   NR read enables
//   we       in   NW write enables
//   waddr    in   NW*AW write addresses
//   wdata    in   NW*DW write data
//   stall    in   hold read outputs
//   flush    in   squash read outputs (beats stall)
//   clr_req  in   single-cycle full-clear request
//   busy     out  clear in progress
//
// Handshake: there is no back-pressure. A read issued with re[i]=1 on an
// unstalled, unflushed cycle in RUN produces rvalid[i]=1 with its data on the
// next cycle; rvalid/rdata then hold until the next unstalled cycle.
// ---------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int NR       = DEF_NR,
  parameter int NW       = DEF_NW,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata,
  output logic [NR-1:0]    rvalid,
  input  logic [NR-1:0]    re,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] waddr,
  input  logic [NW*DW-1:0] wdata,
  input  logic             stall,
  input  logic             flush,
  input  logic             clr_req,
  output logic             busy
);

  // ---------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------
  state_t        clr_state;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          run;

  regfile_mp_clr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .state    (clr_state),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign run = (clr_state == ST_RUN);

  // ---------------------------------------------------------------------
  // Write ports: a write commits only in RUN, not in the cycle a clear is
  // requested, and never to r0 when ZERO_REG is set.
  // ---------------------------------------------------------------------
  logic [NW-1:0] wr_act;

  always_comb begin
    wr_act = '0;
    for (int p = 0; p < NW; p++) begin
      wr_act[p] = run && we[p] && !clr_req &&
                  !((ZERO_REG != 0) && (waddr[p*AW +: AW] == '0));
    end
  end

  // ---------------------------------------------------------------------
  // Storage. Contents are not reset; the sequencer zeroes them.
  // ---------------------------------------------------------------------
  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] mem_we;

  always_comb begin
    logic [MAX_NW-1:0] hit;
    for (int e = 0; e < DEPTH; e++) begin
      hit = '0;
      for (int p = 0; p < NW; p++) begin
        hit[p] = wr_act[p] && (waddr[p*AW +: AW] == AW'(e));
      end
      // Clear writes and port writes never coincide: one needs CLEAR, the
      // other RUN.
      if (clr_we && (clr_addr == AW'(e))) begin
        mem_we[e] = 1'b1;
        mem_d[e]  = '0;
      end else begin
        mem_we[e] = |hit;
        mem_d[e]  = wdata[win_port(hit)*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (mem_we[e]) mem_q[e] <= mem_d[e];
    end
  end

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rval;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;

    assign ra = raddr[i*AW +: AW];

    always_comb begin
`ifdef REGFILE_MP_BYPASS_EN
      logic [MAX_NW-1:0] hit;
      hit = '0;
      for (int p = 0; p < NW; p++) begin
        hit[p] = wr_act[p] && (waddr[p*AW +: AW] == ra);
      end
`endif
      rval = mem_q[ra];
`ifdef REGFILE_MP_BYPASS_EN
      if (|hit) rval = wdata[win_port(hit)*DW +: DW];
`endif
      if ((ZERO_REG != 0) && (ra == '0)) rval = '0;
    end

    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      if (!run) begin
        rdata_d  = '0;
        rvalid_d = 1'b0;
      end else if (flush) begin
        rdata_d  = '0;
        rvalid_d = 1'b0;
      end else if (!stall) begin
        rvalid_d = re[i];
        if (re[i]) rdata_d = rval;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign rdata[i*DW +: DW] = rdata_q;
    assign rvalid[i]         = rvalid_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rvalid;
  logic [NR-1:0]    re = '0;
  logic [NW-1:0]    we = '0;
  logic [NW*AW-1:0] waddr = '0;
  logic [NW*DW-1:0] wdata = '0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             clr_req = 1'b0;
  logic             busy;

  regfile_mp #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .re(re), .we(we), .waddr(waddr), .wdata(wdata), .stall(stall),
    .flush(flush), .clr_req(clr_req), .busy(busy)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Behavioural view: a plain array, a "cycles of clearing left" count and
  // the last read results per port.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rd  [NR];
  logic [NR-1:0] m_rv;
  int clear_left;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_rd[i] = '0;
    m_rv = '0;
    clear_left = DEPTH;
  endtask

  task automatic model_edge();
    logic [31:0] new_mem [DEPTH];
    int a;
    if (!rst) return;
    if (clear_left > 0) begin
      m_mem[DEPTH - clear_left] = '0;
      clear_left--;
      for (int i = 0; i < NR; i++) m_rd[i] = '0;
      m_rv = '0;
    end else begin
      new_mem = m_mem;
      if (!clr_req) begin
        for (int p = 0; p < NW; p++) begin
          a = int'(waddr[p*AW +: AW]);
          if (we[p] && a != 0) new_mem[a] = wdata[p*DW +: DW];
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (flush) begin
          m_rd[i] = '0;
          m_rv[i] = 1'b0;
        end else if (!stall) begin
          m_rv[i] = re[i];
          if (re[i]) begin
            a = int'(raddr[i*AW +: AW]);
            if (a == 0)   m_rd[i] = '0;
            else if (BYP) m_rd[i] = new_mem[a];
            else          m_rd[i] = m_mem[a];
          end
        end
      end
      m_mem = new_mem;
      if (clr_req) clear_left = DEPTH;
    end
  endtask

  task automatic compare_all();
    check("rdata0", rdata[31:0],  m_rd[0]);
    check("rdata1", rdata[63:32], m_rd[1]);
    check("rvalid", 32'(rvalid),  32'(m_rv));
    check("busy",   32'(busy),    32'(clear_left > 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    we = '0; re = '0; stall = 1'b0; flush = 1'b0; clr_req = 1'b0;
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (busy && n < 200) begin
      cycle();
      n++;
    end
    check(nm, n, 32);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic        stall, flush, clr;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_rv;
    logic        e_busy;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(
    input logic [1:0] w, input logic [4:0] wa0, input logic [31:0] wd0,
    input logic [4:0] wa1, input logic [31:0] wd1,
    input logic [1:0] r, input logic [4:0] ra0, input logic [4:0] ra1,
    input logic st, input logic fl, input logic cl,
    input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] erv, input logic eb);
    vec_t v;
    v.we = w; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.re = r; v.ra0 = ra0; v.ra1 = ra1; v.stall = st; v.flush = fl; v.clr = cl;
    v.e_rd0 = e0; v.e_rd1 = e1; v.e_rv = erv; v.e_busy = eb;
    return v;
  endfunction

  initial begin
    logic [31:0] r3_new;
    r3_new = BYP ? 32'hA5A5A5A5 : 32'h33333333;

    //                we     wa0  wd0           wa1  wd1           re     ra0 ra1 st fl cl  rd0           rd1           rv     busy
    vecs[0]  = mk(2'b01, 5,  32'hDEADBEEF, 0,  32'h0,        2'b00, 0,  0,  0, 0, 0, 32'h0,        32'h0,        2'b00, 0);
    vecs[1]  = mk(2'b01, 0,  32'h00001234, 0,  32'h0,        2'b11, 5,  0,  0, 0, 0, 32'hDEADBEEF, 32'h0,        2'b11, 0);
    vecs[2]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b10, 0,  0,  0, 0, 0, 32'hDEADBEEF, 32'h0,        2'b10, 0);
    vecs[3]  = mk(2'b11, 7,  32'h00000011, 7,  32'h00000022, 2'b00, 0,  0,  0, 0, 0, 32'hDEADBEEF, 32'h0,        2'b00, 0);
    vecs[4]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b01, 7,  0,  0, 0, 0, 32'h00000022, 32'h0,        2'b01, 0);
    vecs[5]  = mk(2'b01, 3,  32'h33333333, 0,  32'h0,        2'b00, 0,  0,  0, 0, 0, 32'h00000022, 32'h0,        2'b00, 0);
    vecs[6]  = mk(2'b10, 0,  32'h0,        3,  32'hA5A5A5A5, 2'b01, 3,  0,  0, 0, 0, r3_new,       32'h0,        2'b01, 0);
    vecs[7]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b11, 3,  5,  0, 0, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b11, 0);
    vecs[8]  = mk(2'b01, 10, 32'hCAFE0001, 0,  32'h0,        2'b11, 7,  0,  1, 0, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b11, 0);
    vecs[9]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b00, 10, 7,  1, 0, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b11, 0);
    vecs[10] = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b11, 1,  2,  1, 0, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b11, 0);
    vecs[11] = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b11, 1,  2,  1, 1, 0, 32'h0,        32'h0,        2'b00, 0);
    vecs[12] = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b11, 10, 7,  0, 0, 0, 32'hCAFE0001, 32'h00000022, 2'b11, 0);
    vecs[13] = mk(2'b11, 12, 32'h00000012, 13, 32'h00000013, 2'b00, 0,  0,  0, 0, 0, 32'hCAFE0001, 32'h00000022, 2'b00, 0);
    vecs[14] = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b11, 12, 13, 0, 0, 0, 32'h00000012, 32'h00000013, 2'b11, 0);
    vecs[15] = mk(2'b01, 9,  32'h00000099, 0,  32'h0,        2'b11, 12, 13, 0, 0, 1, 32'h00000012, 32'h00000013, 2'b11, 1);
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int e = 0; e < DEPTH; e++) m_mem[e] = '0;
    model_reset();

    // Reset held: outputs at reset values.
    #1;
    compare_all();
    for (int k = 0; k < 3; k++) cycle();

    // Release reset between edges, then idle through the initial clear.
    rst = 1'b1;
    count_busy("init_busy_len");

    // Every address reads 0 with rvalid=1.
    for (int a = 0; a < DEPTH; a++) begin
      re = 2'b11;
      raddr = {5'(DEPTH - 1 - a), 5'(a)};
      cycle();
    end
    idle();

    // Directed table.
    for (int v = 0; v < 16; v++) begin
      we      = vecs[v].we;
      waddr   = {vecs[v].wa1, vecs[v].wa0};
      wdata   = {vecs[v].wd1, vecs[v].wd0};
      re      = vecs[v].re;
      raddr   = {vecs[v].ra1, vecs[v].ra0};
      stall   = vecs[v].stall;
      flush   = vecs[v].flush;
      clr_req = vecs[v].clr;
      cycle();
      check($sformatf("vec%0d_rd0", v), rdata[31:0], vecs[v].e_rd0);
      check($sformatf("vec%0d_rd1", v), rdata[63:32], vecs[v].e_rd1);
      check($sformatf("vec%0d_rv", v), 32'(rvalid), 32'(vecs[v].e_rv));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].e_busy));
    end
    idle();

    // Clear requested by the last table row: busy for 32 cycles, with
    // writes ignored during the clear.
    we = 2'b11; waddr = {5'd20, 5'd21}; wdata = {32'h2020, 32'h2121};
    count_busy("clr_busy_len");
    idle();
    re = 2'b11; raddr = {5'd12, 5'd9};
    cycle();
    check("r9_after_clr",  rdata[31:0],  32'h0);
    check("r12_after_clr", rdata[63:32], 32'h0);
    raddr = {5'd20, 5'd21};
    cycle();
    check("r21_clr_write_dropped", rdata[31:0],  32'h0);
    check("r20_clr_write_dropped", rdata[63:32], 32'h0);
    idle();

    // Reset pulsed 10 cycles into a clear: sequence restarts from release.
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) cycle();
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    cycle();
    cycle();
    rst = 1'b1;
    count_busy("rst_mid_clr_busy_len");

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      we      = 2'($urandom_range(0, 3));
      waddr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wdata   = {$urandom, $urandom};
      re      = 2'($urandom_range(0, 3));
      raddr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      stall   = ($urandom_range(0, 7) == 0);
      flush   = ($urandom_range(0, 15) == 0);
      clr_req = ($urandom_range(0, 99) == 0);
      cycle();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file, successor to the 2R/1W decode-stage file.
- Provides NR registered read ports and NW write ports, with write-to-read bypass and a write-port priority rule.
- Includes a hardware clear sequencer, run on reset and on request, that zeroes the whole array.
- Sits in the ID stage: read data feeds the ID/EX operands, and writes arrive from WB.

Parameters:
- DW, 32: data width.
- DEPTH, 32: number of registers; power of two, at least 2.
- AW, $clog2(DEPTH): address width (derived).
- NR, 2: number of read ports, 1..4.
- NW, 1: number of write ports, 1..2.
- ZERO_REG, 1: when 1, register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- raddr  in  NR*AW  read addresses; port i occupies slice [i*AW +: AW].
- rdata  out  NR*DW  registered read data.
- rvalid  out  NR  read data valid, one bit per port.
- re  in  NR  read enable, one bit per port.
- we  in  NW  write enable, one bit per port.
- waddr  in  NW*AW  write addresses.
- wdata  in  NW*DW  write data.
- stall  in  1  hold read outputs.
- flush  in  1  squash read outputs.
- clr_req  in  1  single-cycle pulse requesting a full array clear.
- busy  out  1  high while the clear sequencer is active.

Behaviour:
- Reset (rst=0, asynchronous):
  - rdata=0, rvalid=0, busy=1.
  - FSM enters CLEAR; clear counter cnt=0.
  - Array contents are not reset directly; the sequencer clears them.
- FSM states:
  - CLEAR: write 0 to entry cnt each cycle; cnt increments. When cnt=DEPTH-1, go to RUN on the next edge. busy=1 throughout. Duration is exactly DEPTH cycles.
  - RUN: normal operation, busy=0. clr_req=1 sets cnt=0 and moves to CLEAR.
- In CLEAR:
  - All we are ignored; rvalid forced to 0; rdata held at 0.
  - clr_req is ignored; it does not restart the count.
- Writes (RUN only):
  - Committed at the clock edge, independent of stall and flush.
  - With ZERO_REG=1, writes to address 0 are dropped.
  - Two ports writing the same address: port NW-1 (highest index) wins.
- Reads: one-cycle latency. At each edge, for port i:
  - If flush=1: rdata[i]<=0, rvalid[i]<=0. flush has priority over stall.
  - Else if stall=1: rdata[i] and rvalid[i] hold.
  - Else: rvalid[i]<=re[i]. If re[i]=1, rdata[i]<=value(raddr[i]); if re[i]=0, rdata[i] holds.
- value(a):
  - 0 if ZERO_REG=1 and a=0.
  - Else, with bypass compiled in, the highest-index active same-cycle write whose address matches a.
  - Else the array contents.
- Simultaneous clr_req and a write in RUN: the write is dropped and the clear starts.
- Reset asserted mid-CLEAR: the sequence restarts from cnt=0.
- cnt is AW+1 bits wide, so it cannot wrap before the terminal compare.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: same-cycle write data is forwarded into the read register (write-first). A read issued in the cycle of the write returns the new value one cycle later.
- Not defined: reads capture the array before the write (read-first). Forwarding is then the pipeline's responsibility. The priority rule still applies to the array contents.

Decomposition:
- Shared package regfile_pkg:
  - FSM state typedef: CLEAR, RUN.
  - Default constants DW=32, DEPTH=32, NR=2, NW=1.
  - Function to select the winning write port for an address.
- One natural sub-module: regfile_mp_clr, the clear sequencer (FSM, cnt, busy, clear write address and enable), muxed ahead of the write ports.
- Read ports are generated in a loop.

Test Plan:
- Reset release, then idle:
  - busy stays 1 for exactly 32 cycles, then 0.
  - Read of every address returns 0 with rvalid=1.
- RUN: write r5=0xDEADBEEF; next cycle read port 0 with raddr=5, re=1:
  - rdata[0]=0xDEADBEEF one cycle later.
  - raddr=0 on port 1 gives 0, even after a write of 0x1234 to r0.
- Same cycle: NW=2, both ports write r7 (0x11 on port 0, 0x22 on port 1):
  - Subsequent read of r7 returns 0x22.
- Same-cycle write r3=0xA5A5A5A5 and read r3:
  - With REGFILE_MP_BYPASS_EN: rdata=0xA5A5A5A5.
  - Without: rdata equals the old r3 value.
- stall=1 for 3 cycles while raddr changes: rdata and rvalid hold.
  - flush=1 during the stall: next cycle rdata=0, rvalid=0.
  - A write issued during the stall still commits.
- clr_req mid-run, with a write to r9 in the same cycle:
  - busy=1 for 32 cycles; r9 reads 0 afterwards.
  - rst pulsed at cycle 10 of the clear: busy lasts 32 cycles from the release of rst.
